// File: rtl/pwm_reg_arbiter_if.sv
// Write-request bundle between PWM register requesters and pwm_reg_arbiter.
// Requester i uses addr bits [7i+6:7i] and data bits [8i+7:8i]; ready is a one-hot grant.
interface pwm_reg_arbiter_if #(
    parameter int NREQ = 2
);
    logic [NREQ-1:0]   req_valid;
    logic [7*NREQ-1:0] req_addr;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_ready;

    modport master (output req_valid, req_addr, req_data, input req_ready);
    modport slave  (input req_valid, req_addr, req_data, output req_ready);
endinterface

// File: rtl/pwm_reg_arbiter.sv
// Round-robin arbiter committing one byte-write per cycle into the five PWM configuration registers.
// Define PWM_ARB_SHADOW_EN to stage writes in shadow registers that go live on the commit strobe.
module pwm_reg_arbiter #(
    parameter int NREQ  = 2,
    parameter int PTR_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    pwm_reg_arbiter_if.slave bus,
    input  logic             commit,
    output logic [7:0]       out_en_reg_7_0,
    output logic [7:0]       out_en_reg_15_8,
    output logic [7:0]       out_en_pwm_7_0,
    output logic [7:0]       out_en_pwm_15_8,
    output logic [7:0]       out_pwm_duty_cycle,
    output logic             err_addr,
    output logic [PTR_W-1:0] last_grant
);
    localparam int NREG = 5;

    logic [PTR_W-1:0] ptr;
    logic [NREQ-1:0]  grant;
    logic [PTR_W-1:0] grant_idx;
    logic             accept;
    logic [6:0]       sel_addr;
    logic [7:0]       sel_data;
    logic [NREG-1:0]  wr_en;
    logic [7:0]       live [NREG];

    // Search from ptr upward, wrapping at NREQ; the first valid requester wins.
    always_comb begin
        int pos;
        grant     = '0;
        grant_idx = '0;
        accept    = 1'b0;
        pos       = 0;
        if (!rst) begin
            for (int k = 0; k < NREQ; k++) begin
                pos = int'(ptr) + k;
                if (pos >= NREQ) pos = pos - NREQ;
                for (int i = 0; i < NREQ; i++) begin
                    if (!accept && pos == i && bus.req_valid[i]) begin
                        accept    = 1'b1;
                        grant[i]  = 1'b1;
                        grant_idx = PTR_W'(i);
                    end
                end
            end
        end
    end

    assign bus.req_ready = grant;

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_addr = bus.req_addr[7*i +: 7];
                sel_data = bus.req_data[8*i +: 8];
            end
        end
    end

    // Out-of-map addresses are accepted but hit no register.
    always_comb begin
        wr_en = '0;
        for (int r = 0; r < NREG; r++) begin
            wr_en[r] = accept && (sel_addr == 7'(r));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr        <= '0;
            last_grant <= '0;
            err_addr   <= 1'b0;
        end else begin
            err_addr <= accept && (sel_addr > 7'(NREG - 1));
            if (accept) begin
                last_grant <= grant_idx;
                ptr        <= (grant_idx == PTR_W'(NREQ - 1)) ? '0 : grant_idx + PTR_W'(1);
            end
        end
    end

`ifdef PWM_ARB_SHADOW_EN
    logic [7:0] shadow [NREG];

    // Commit copies the shadow as it stood before any same-cycle write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                shadow[r] <= '0;
                live[r]   <= '0;
            end
        end else begin
            for (int r = 0; r < NREG; r++) begin
                if (commit)   live[r]   <= shadow[r];
                if (wr_en[r]) shadow[r] <= sel_data;
            end
        end
    end
`else
    logic unused_commit;
    assign unused_commit = commit;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) live[r] <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                if (wr_en[r]) live[r] <= sel_data;
            end
        end
    end
`endif

    assign out_en_reg_7_0     = live[0];
    assign out_en_reg_15_8    = live[1];
    assign out_en_pwm_7_0     = live[2];
    assign out_en_pwm_15_8    = live[3];
    assign out_pwm_duty_cycle = live[4];

endmodule

// File: tb/tb_pwm_reg_arbiter.sv
// Scoreboard bench for pwm_reg_arbiter: directed vectors push expected grants and post-cycle
// register images; an independent monitor pops and compares them as the DUT presents them.
module tb_pwm_reg_arbiter;
    localparam int NREQ  = 2;
    localparam int PTR_W = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             commit = 1'b0;
    logic [7:0]       out_en_reg_7_0, out_en_reg_15_8, out_en_pwm_7_0, out_en_pwm_15_8, out_pwm_duty_cycle;
    logic             err_addr;
    logic [PTR_W-1:0] last_grant;

    pwm_reg_arbiter_if #(.NREQ(NREQ)) bus ();

    pwm_reg_arbiter #(.NREQ(NREQ), .PTR_W(PTR_W)) dut (
        .clk                (clk),
        .rst                (rst),
        .bus                (bus),
        .commit             (commit),
        .out_en_reg_7_0     (out_en_reg_7_0),
        .out_en_reg_15_8    (out_en_reg_15_8),
        .out_en_pwm_7_0     (out_en_pwm_7_0),
        .out_en_pwm_15_8    (out_en_pwm_15_8),
        .out_pwm_duty_cycle (out_pwm_duty_cycle),
        .err_addr           (err_addr),
        .last_grant         (last_grant)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0]      due;
        logic [39:0]      regs;
        logic             err;
        logic [PTR_W-1:0] last;
    } state_t;

    logic [NREQ-1:0] grant_q [$];
    state_t          state_q [$];
    logic [7:0]      exp_regs [5];
    logic [31:0]     cyc = '0;
    int              checks = 0;
    int              passes = 0;
    state_t          mon_s;
    logic [NREQ-1:0] mon_g;

    always @(posedge clk) cyc <= cyc + 32'd1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act === expv) passes++;
        else $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
    endtask

    // Grants are checked whenever ready appears; register images once their cycle has elapsed.
    always @(negedge clk) begin
        if (bus.req_ready != '0) begin
            if (grant_q.size() == 0) begin
                checkOutput("grant_unexpected", 64'(bus.req_ready), 64'd0);
            end else begin
                mon_g = grant_q.pop_front();
                checkOutput("grant", 64'(bus.req_ready), 64'(mon_g));
            end
        end
        while (state_q.size() > 0 && state_q[0].due <= cyc) begin
            mon_s = state_q.pop_front();
            checkOutput("regs", 64'({out_pwm_duty_cycle, out_en_pwm_15_8, out_en_pwm_7_0,
                                     out_en_reg_15_8, out_en_reg_7_0}), 64'(mon_s.regs));
            checkOutput("err_addr", 64'(err_addr), 64'(mon_s.err));
            checkOutput("last_grant", 64'(last_grant), 64'(mon_s.last));
        end
    end

    // exp_regs must hold the expected live image after this cycle before calling.
    task automatic applyStimulus(input logic r, input logic [NREQ-1:0] v,
                                 input logic [6:0] a0, input logic [7:0] d0,
                                 input logic [6:0] a1, input logic [7:0] d1,
                                 input logic c, input logic [NREQ-1:0] exp_ready,
                                 input logic [PTR_W-1:0] exp_last, input logic exp_err);
        state_t s;
        rst           = r;
        bus.req_valid = v;
        bus.req_addr  = {a1, a0};
        bus.req_data  = {d1, d0};
        commit        = c;
        if (exp_ready != '0) grant_q.push_back(exp_ready);
        s.due  = cyc + 32'd1;
        s.regs = {exp_regs[4], exp_regs[3], exp_regs[2], exp_regs[1], exp_regs[0]};
        s.err  = exp_err;
        s.last = exp_last;
        state_q.push_back(s);
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 5; i++) exp_regs[i] = 8'h00;
        bus.req_valid = '0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        @(posedge clk);
        #1;

        // Reset with every requester asking: no grant, everything cleared
        applyStimulus(1'b1, 2'b11, 7'd0, 8'hAA, 7'd1, 8'hBB, 1'b0, 2'b00, 3'd0, 1'b0);
        applyStimulus(1'b1, 2'b11, 7'd0, 8'hAA, 7'd1, 8'hBB, 1'b0, 2'b00, 3'd0, 1'b0);

`ifdef PWM_ARB_SHADOW_EN
        applyStimulus(1'b0, 2'b01, 7'd2, 8'h0F, 7'd0, 8'h00, 1'b0, 2'b01, 3'd0, 1'b0);
        exp_regs[2] = 8'h0F;
        applyStimulus(1'b0, 2'b00, 7'd0, 8'h00, 7'd0, 8'h00, 1'b1, 2'b00, 3'd0, 1'b0);
        applyStimulus(1'b0, 2'b10, 7'd0, 8'h00, 7'd2, 8'hF0, 1'b1, 2'b10, 3'd1, 1'b0);
        exp_regs[2] = 8'hF0;
        applyStimulus(1'b0, 2'b00, 7'd0, 8'h00, 7'd0, 8'h00, 1'b1, 2'b00, 3'd1, 1'b0);
        applyStimulus(1'b0, 2'b01, 7'd5, 8'hFF, 7'd0, 8'h00, 1'b0, 2'b01, 3'd0, 1'b1);
        applyStimulus(1'b0, 2'b00, 7'd0, 8'h00, 7'd0, 8'h00, 1'b1, 2'b00, 3'd0, 1'b0);
`else
        // First grant after release goes to requester 0
        exp_regs[0] = 8'h5A;
        applyStimulus(1'b0, 2'b11, 7'd0, 8'h5A, 7'd1, 8'h3C, 1'b0, 2'b01, 3'd0, 1'b0);
        exp_regs[1] = 8'h3C;
        applyStimulus(1'b0, 2'b11, 7'd0, 8'h5A, 7'd1, 8'h3C, 1'b0, 2'b10, 3'd1, 1'b0);

        // Single write from requester 1, then an idle cycle where commit must be ignored
        exp_regs[4] = 8'h80;
        applyStimulus(1'b0, 2'b10, 7'd0, 8'h00, 7'd4, 8'h80, 1'b0, 2'b10, 3'd1, 1'b0);
        applyStimulus(1'b0, 2'b00, 7'd0, 8'h00, 7'd0, 8'h00, 1'b1, 2'b00, 3'd1, 1'b0);

        // Fairness: both continuously valid, grants alternate 0,1,0,1,0,1
        exp_regs[0] = 8'h10;
        applyStimulus(1'b0, 2'b11, 7'd0, 8'h10, 7'd1, 8'h11, 1'b0, 2'b01, 3'd0, 1'b0);
        exp_regs[1] = 8'h11;
        applyStimulus(1'b0, 2'b11, 7'd0, 8'h10, 7'd1, 8'h11, 1'b0, 2'b10, 3'd1, 1'b0);
        exp_regs[2] = 8'h20;
        applyStimulus(1'b0, 2'b11, 7'd2, 8'h20, 7'd3, 8'h21, 1'b0, 2'b01, 3'd0, 1'b0);
        exp_regs[3] = 8'h21;
        applyStimulus(1'b0, 2'b11, 7'd2, 8'h20, 7'd3, 8'h21, 1'b0, 2'b10, 3'd1, 1'b0);
        exp_regs[4] = 8'h30;
        applyStimulus(1'b0, 2'b11, 7'd4, 8'h30, 7'd0, 8'h31, 1'b0, 2'b01, 3'd0, 1'b0);
        exp_regs[0] = 8'h31;
        applyStimulus(1'b0, 2'b11, 7'd4, 8'h30, 7'd0, 8'h31, 1'b0, 2'b10, 3'd1, 1'b0);

        // Out-of-map addresses: accepted, registers untouched, err_addr follows
        applyStimulus(1'b0, 2'b01, 7'd5, 8'hFF, 7'd0, 8'h00, 1'b0, 2'b01, 3'd0, 1'b1);
        applyStimulus(1'b0, 2'b10, 7'd0, 8'h00, 7'h7F, 8'hEE, 1'b0, 2'b10, 3'd1, 1'b1);
        applyStimulus(1'b0, 2'b00, 7'd0, 8'h00, 7'd0, 8'h00, 1'b0, 2'b00, 3'd1, 1'b0);

        // Collision on address 0: 0x11 for one cycle, then 0x22
        exp_regs[0] = 8'h11;
        applyStimulus(1'b0, 2'b11, 7'd0, 8'h11, 7'd0, 8'h22, 1'b0, 2'b01, 3'd0, 1'b0);
        exp_regs[0] = 8'h22;
        applyStimulus(1'b0, 2'b11, 7'd0, 8'h11, 7'd0, 8'h22, 1'b0, 2'b10, 3'd1, 1'b0);
        applyStimulus(1'b0, 2'b00, 7'd0, 8'h00, 7'd0, 8'h00, 1'b0, 2'b00, 3'd1, 1'b0);

        // Pointer skips idle requesters and wraps
        exp_regs[2] = 8'h77;
        applyStimulus(1'b0, 2'b10, 7'd0, 8'h00, 7'd2, 8'h77, 1'b0, 2'b10, 3'd1, 1'b0);
        exp_regs[3] = 8'h66;
        applyStimulus(1'b0, 2'b01, 7'd3, 8'h66, 7'd0, 8'h00, 1'b0, 2'b01, 3'd0, 1'b0);
        exp_regs[1] = 8'h99;
        applyStimulus(1'b0, 2'b01, 7'd1, 8'h99, 7'd0, 8'h00, 1'b0, 2'b01, 3'd0, 1'b0);

        // Reset wins over a same-cycle write and restarts the pointer at 0
        for (int i = 0; i < 5; i++) exp_regs[i] = 8'h00;
        applyStimulus(1'b1, 2'b11, 7'd0, 8'hAA, 7'd1, 8'hBB, 1'b0, 2'b00, 3'd0, 1'b0);
        exp_regs[4] = 8'h42;
        applyStimulus(1'b0, 2'b10, 7'd0, 8'h00, 7'd4, 8'h42, 1'b0, 2'b10, 3'd1, 1'b0);
        applyStimulus(1'b0, 2'b00, 7'd0, 8'h00, 7'd0, 8'h00, 1'b0, 2'b00, 3'd1, 1'b0);
`endif

        @(negedge clk);
        #1;
        @(negedge clk);
        #1;
        checkOutput("pending_grants", 64'(grant_q.size()), 64'd0);
        checkOutput("pending_states", 64'(state_q.size()), 64'd0);
        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
